// File: rtl/mole_demux.sv
// Registered 1-to-4 mole demultiplexer. Each lit channel holds for HOLD_CYCLES
// clocks and then drops with a one-cycle expired pulse (HOLD_CYCLES=0 holds forever).
module mole_demux #(
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       se1,
  input  logic       se2,
  input  logic       load,
  input  logic       clear,
  output logic       d1,
  output logic       d2,
  output logic       d3,
  output logic       d4,
  output logic [3:0] expired,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = '0;

  // load and clear are single-cycle command strobes sampled at each rising
  // edge; there is no back-pressure, every command is accepted immediately.
  logic [1:0]       sel;
  logic [3:0]       d_q;
  logic [3:0]       d_n;
  logic [3:0]       exp_n;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_n [4];

  assign sel = {se1, se2};

  always_comb begin
    d_n   = d_q;
    exp_n = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cnt_n[i] = cnt_q[i];
      if (clear) begin
        d_n[i]   = 1'b0;
        cnt_n[i] = ZERO;
      end else if (load && (sel == 2'(i))) begin
        // A load on the expiry edge wins: the timeout is simply discarded.
        d_n[i]   = din;
        cnt_n[i] = din ? HOLD : ZERO;
      end else if (cnt_q[i] == ONE) begin
        d_n[i]   = 1'b0;
        cnt_n[i] = ZERO;
        exp_n[i] = 1'b1;
      end else if (cnt_q[i] != ZERO) begin
        cnt_n[i] = cnt_q[i] - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q     <= 4'b0000;
      expired <= 4'b0000;
      busy    <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= ZERO;
    end else begin
      d_q     <= d_n;
      expired <= exp_n;
      busy    <= |d_n;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_n[i];
    end
  end

  assign d1 = d_q[0];
  assign d2 = d_q[1];
  assign d3 = d_q[2];
  assign d4 = d_q[3];

endmodule

// File: tb/tb_mole_demux.sv
// Directed bench for mole_demux: a HOLD_CYCLES=8 instance and a HOLD_CYCLES=0
// instance share inputs; per-cycle expected outputs go through a scoreboard queue.
module tb_mole_demux;

  logic       clk;
  logic       rst;
  logic       din;
  logic       se1;
  logic       se2;
  logic       load;
  logic       clear;

  logic       a_d1, a_d2, a_d3, a_d4, a_busy;
  logic [3:0] a_expired;
  logic       b_d1, b_d2, b_d3, b_d4, b_busy;
  logic [3:0] b_expired;

  // Entry: {which dut, d4..d1, expired, busy}
  logic [9:0] exp_q[$];
  int         checks;
  int         failures;
  int         cycle_no;

  mole_demux #(.HOLD_CYCLES(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .din(din), .se1(se1), .se2(se2),
    .load(load), .clear(clear),
    .d1(a_d1), .d2(a_d2), .d3(a_d3), .d4(a_d4),
    .expired(a_expired), .busy(a_busy)
  );

  mole_demux #(.HOLD_CYCLES(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .din(din), .se1(se1), .se2(se2),
    .load(load), .clear(clear),
    .d1(b_d1), .d2(b_d2), .d3(b_d3), .d4(b_d4),
    .expired(b_expired), .busy(b_busy)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks: inputs change on the falling edge, the expectation for the
  // following rising edge is queued at the same time.
  task automatic cyc(input logic r, input logic c, input logic l, input logic dn,
                     input logic [1:0] s, input logic [3:0] ed, input logic [3:0] ee,
                     input logic which);
    @(negedge clk);
    rst   = r;
    clear = c;
    load  = l;
    din   = dn;
    {se1, se2} = s;
    exp_q.push_back({which, ed, ee, |ed});
  endtask

  task automatic idle(input int n, input logic [3:0] ed, input logic [3:0] ee,
                      input logic which);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, ed, ee, which);
  endtask

  task automatic ld(input logic [1:0] s, input logic dn, input logic [3:0] ed,
                    input logic [3:0] ee);
    cyc(1'b0, 1'b0, 1'b1, dn, s, ed, ee, 1'b0);
  endtask

  // Scoreboard monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    logic [9:0] e;
    logic [8:0] act;
    #1;
    cycle_no++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e[9]) act = {b_d4, b_d3, b_d2, b_d1, b_expired, b_busy};
      else      act = {a_d4, a_d3, a_d2, a_d1, a_expired, a_busy};
      checks++;
      if (act !== e[8:0]) begin
        failures++;
        $display("FAIL outputs cycle=%0d dut=%s d4..d1=%b exp=%b expired=%b exp=%b busy=%b exp=%b",
                 cycle_no, e[9] ? "hold0" : "hold8", act[8:5], e[8:5],
                 act[4:1], e[4:1], act[0], e[0]);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    cycle_no = 0;
    rst = 1'b1; clear = 1'b0; load = 1'b0; din = 1'b0; se1 = 1'b0; se2 = 1'b0;

    // Reset dominates a pending load, then the same load takes effect.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 4'b0000, 4'b0000, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 4'b0000, 4'b0000, 1'b0);
    ld(2'b00, 1'b1, 4'b0001, 4'b0000);
    idle(7, 4'b0001, 4'b0000, 1'b0);
    idle(1, 4'b0000, 4'b0001, 1'b0);
    idle(1, 4'b0000, 4'b0000, 1'b0);

    // Basic route to d3: 8 cycles high, expiry pulse on the first low cycle.
    ld(2'b10, 1'b1, 4'b0100, 4'b0000);
    idle(7, 4'b0100, 4'b0000, 1'b0);
    idle(1, 4'b0000, 4'b0100, 1'b0);
    idle(1, 4'b0000, 4'b0000, 1'b0);

    // Restart d2 five cycles after first load: 13 continuous high cycles.
    ld(2'b01, 1'b1, 4'b0010, 4'b0000);
    idle(4, 4'b0010, 4'b0000, 1'b0);
    ld(2'b01, 1'b1, 4'b0010, 4'b0000);
    idle(7, 4'b0010, 4'b0000, 1'b0);
    idle(1, 4'b0000, 4'b0010, 1'b0);
    idle(1, 4'b0000, 4'b0000, 1'b0);

    // Reload d1 exactly on its expiry edge: no pulse, another 8 cycles.
    ld(2'b00, 1'b1, 4'b0001, 4'b0000);
    idle(7, 4'b0001, 4'b0000, 1'b0);
    ld(2'b00, 1'b1, 4'b0001, 4'b0000);
    idle(7, 4'b0001, 4'b0000, 1'b0);
    idle(1, 4'b0000, 4'b0001, 1'b0);
    idle(1, 4'b0000, 4'b0000, 1'b0);

    // d4 expires on the same edge that loads d1.
    ld(2'b11, 1'b1, 4'b1000, 4'b0000);
    idle(7, 4'b1000, 4'b0000, 1'b0);
    ld(2'b00, 1'b1, 4'b0001, 4'b1000);
    idle(7, 4'b0001, 4'b0000, 1'b0);
    idle(1, 4'b0000, 4'b0001, 1'b0);
    idle(1, 4'b0000, 4'b0000, 1'b0);

    // Light all four, then clear; no late expiries afterwards.
    ld(2'b00, 1'b1, 4'b0001, 4'b0000);
    ld(2'b01, 1'b1, 4'b0011, 4'b0000);
    ld(2'b10, 1'b1, 4'b0111, 4'b0000);
    ld(2'b11, 1'b1, 4'b1111, 4'b0000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0);
    idle(12, 4'b0000, 4'b0000, 1'b0);

    // Clear on the expiry edge suppresses the pulse.
    ld(2'b00, 1'b1, 4'b0001, 4'b0000);
    idle(7, 4'b0001, 4'b0000, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0);
    idle(3, 4'b0000, 4'b0000, 1'b0);

    // din=0 turns d3 off immediately with no pulse.
    ld(2'b10, 1'b1, 4'b0100, 4'b0000);
    idle(2, 4'b0100, 4'b0000, 1'b0);
    ld(2'b10, 1'b0, 4'b0000, 4'b0000);
    idle(8, 4'b0000, 4'b0000, 1'b0);

    // Reset while d2 counter is 3.
    ld(2'b01, 1'b1, 4'b0010, 4'b0000);
    idle(5, 4'b0010, 4'b0000, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0);
    idle(10, 4'b0000, 4'b0000, 1'b0);

    // HOLD_CYCLES=0 instance: d4 stays lit indefinitely, never expires.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 4'b1000, 4'b0000, 1'b1);
    idle(300, 4'b1000, 4'b0000, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 4'b0000, 4'b0000, 1'b1);
    idle(2, 4'b0000, 4'b0000, 1'b1);

    // Drain the scoreboard.
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mole_demux.md
Name: mole_demux

Overview:
- Registered 1-to-4 demultiplexer with per-channel hold timers. It is the output-side counterpart of the 4:1 input mux.
- The game controller supplies a data bit and a 2-bit select (se1, se2). The block drives one of four mole outputs (d1..d4) and holds each for a programmable number of cycles.
- When a lit mole times out without being cleared, the block raises a one-cycle "expired" pulse for that channel, which the scoring logic consumes.

Parameters:
- HOLD_CYCLES, 8, number of clk cycles a channel stays high after a load with din=1. Value 0 means hold indefinitely, with no timeout and no expire pulses.
- CNT_W, 8, width of each channel hold counter. HOLD_CYCLES must be < 2**CNT_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  data bit routed to the selected channel.
- se1  input  1  select MSB.
- se2  input  1  select LSB.
- load  input  1  when high at a clk edge, din is written to the channel chosen by {se1,se2}.
- clear  input  1  when high at a clk edge, all channels are cleared.
- d1  output  1  channel 0 ({se1,se2}=00), registered.
- d2  output  1  channel 1 (01), registered.
- d3  output  1  channel 2 (10), registered.
- d4  output  1  channel 3 (11), registered.
- expired  output  4  one-cycle pulse per channel on timeout; bit0=d1 ... bit3=d4.
- busy  output  1  registered OR of d1..d4.

Behaviour:
- Reset: while rst is high at an edge, d1..d4=0, all counters=0, expired=4'b0000, busy=0. rst has priority over clear and load.
- Priority after reset: clear, then load, then timer countdown.
- clear: at the edge, d1..d4=0, counters=0, expired=0. Any pending expiry on that edge is suppressed.
- load with din=1:
  - The selected channel output goes to 1 at the edge.
  - Its counter loads HOLD_CYCLES.
  - Unselected channels are unaffected and keep counting.
- load with din=0: the selected channel output goes to 0 and its counter goes to 0 at the edge. No expire pulse.
- Reload of an already-high channel restarts its counter at HOLD_CYCLES; the output stays 1 with no glitch.
- Countdown, per channel, at each edge with no clear and no load to that channel:
  - If counter > 1: counter decrements by 1.
  - If counter == 1: counter goes to 0, output goes to 0, and that channel's expired bit is 1 for exactly the next cycle.
  - If counter == 0: no change.
- Resulting timing: with HOLD_CYCLES=N (N>0), the output is high for exactly N cycles after the load edge. The expired pulse coincides with the first low cycle.
- Load vs expiry on the same edge and channel: the load wins. The output follows din, the counter reloads, and no expire pulse is issued.
- Expiry on one channel and load to another on the same edge: both take effect independently.
- HOLD_CYCLES=0: the counter is never loaded nonzero, so a channel stays high until a load with din=0, clear, or rst. The expired output is constantly 0.
- expired bits default to 0 every cycle unless set by the expiry rule. Multiple bits may be high simultaneously.
- busy is registered from the next-state values of d1..d4, so it is aligned with the outputs in the same cycle.
- Select decode: 00→d1, 01→d2, 10→d3, 11→d4. Select inputs are ignored when load=0.
- Counters use no arithmetic beyond a CNT_W-bit decrement; they never underflow.

Test Plan:
- Reset: assert rst 2 cycles with load=1, din=1, sel=00 → d1..d4=0, expired=0, busy=0 throughout. First edge after rst deasserts with the same inputs → d1=1.
- Basic route, HOLD_CYCLES=8:
  - Stimulus: load=1, din=1, sel=10 for one cycle.
  - Response: d3=1 for exactly 8 cycles, then d3=0 with expired=4'b0100 for one cycle. d1, d2, d4 stay 0 throughout.
- Restart:
  - Stimulus: load d2 (sel=01, din=1); 5 cycles later reload d2.
  - Response: d2 stays high continuously for 5+8=13 cycles, with a single expired=4'b0010 pulse at the end.
- Simultaneous events:
  - Stimulus: load d1; on the exact edge where d1 would expire, load d1 again.
  - Response: no expire pulse, and d1 is high another 8 cycles.
  - Also: on d4's expiry edge, load d1 → expired=4'b1000 and d1=1 in the same cycle.
- Clear and din=0:
  - Stimulus: light all four channels, then assert clear.
  - Response: on the next cycle all outputs are 0, busy=0, and expired=0 forever after.
  - Stimulus: light d3, then load sel=10 with din=0.
  - Response: d3=0 immediately, no expire pulse.
- Mid-operation reset and HOLD_CYCLES=0:
  - Stimulus: assert rst while d2 has a counter of 3.
  - Response: d2=0 and no expire pulse.
  - Re-elaborate with HOLD_CYCLES=0, light d4, and wait 300 cycles → d4 stays 1 and expired stays 0.
